// File: rtl/mips_pkg.sv
// Shared core definitions: ALU op codes, MULTU/DIVU select and sequencer states.
package mips_pkg;
  localparam int XLEN_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic { MD_MULTU = 1'b0, MD_DIVU = 1'b1 } muldiv_op_e;

  typedef enum logic [1:0] { IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2 } md_state_e;

  // One step's request to the shared EX ALU.
  typedef struct packed {
    logic              req;
    logic [3:0]        op;
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
  } alu_req_t;
endpackage

// File: rtl/muldiv_step.sv
// One shift-add (MULTU) or restoring-subtract (DIVU) step; purely combinational.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             active,
  input  muldiv_op_e       op,
  input  logic [XLEN-1:0]  hi,
  input  logic [XLEN-1:0]  lo,
  input  logic [XLEN-1:0]  m,
  input  logic [XLEN-1:0]  alu_result,
  output alu_req_t         alu,
  output logic [XLEN-1:0]  hi_nxt,
  output logic [XLEN-1:0]  lo_nxt
);
  logic [XLEN:0] r;
  logic          ge;
  logic          carry;

  // Partial remainder carries one bit beyond XLEN; r[XLEN] set means r >= D for sure.
  assign r     = {hi, lo[XLEN-1]};
  assign ge    = r[XLEN] | (r[XLEN-1:0] >= m);
  assign carry = alu_result < m;

  always_comb begin
    alu    = '0;
    hi_nxt = hi;
    lo_nxt = lo;
    if (active) begin
      if (op == MD_DIVU) begin
        alu.req = 1'b1;
        alu.op  = ALU_SUB;
        alu.a   = r[XLEN-1:0];
        alu.b   = m;
        hi_nxt  = ge ? alu_result : r[XLEN-1:0];
        lo_nxt  = {lo[XLEN-2:0], ge};
      end else if (lo[0]) begin
        alu.req = 1'b1;
        alu.op  = ALU_ADD;
        alu.a   = hi;
        alu.b   = m;
        hi_nxt  = {carry, alu_result[XLEN-1:1]};
        lo_nxt  = {alu_result[0], lo[XLEN-1:1]};
      end else begin
        hi_nxt  = {1'b0, hi[XLEN-1:1]};
        lo_nxt  = {hi[0], lo[XLEN-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer: 32 steps on the shared EX ALU via req/gnt, result in HI/LO.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [XLEN-1:0]  rt_val,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  lo,
  output logic             div_by_zero,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [XLEN-1:0]  alu_opA,
  output logic [XLEN-1:0]  alu_opB,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result
);
  md_state_e        state, state_nxt;
  muldiv_op_e       op_r;
  logic [XLEN-1:0]  m_r;
  logic [4:0]       cnt;
  alu_req_t         alu;
  logic [XLEN-1:0]  hi_nxt, lo_nxt;
  logic             accept, div0, step_adv;

  assign accept   = (state == IDLE) && start;
  assign div0     = op && (rt_val == '0);
  // A step that needs the ALU only moves when granted; a no-request step always moves.
  assign step_adv = !alu.req || alu_gnt;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .active     (state == RUN),
    .op         (op_r),
    .hi         (hi),
    .lo         (lo),
    .m          (m_r),
    .alu_result (alu_result),
    .alu        (alu),
    .hi_nxt     (hi_nxt),
    .lo_nxt     (lo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div0 ? DONE : RUN;
      RUN:     if (step_adv && cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= MD_MULTU;
      m_r         <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r        <= muldiv_op_e'(op);
      cnt         <= '0;
      div_by_zero <= div0;
      if (div0) begin
        m_r <= rt_val;
        hi  <= rs_val;
        lo  <= '1;
      end else begin
        // MULTU iterates over the multiplier in lo; DIVU shifts the dividend out of lo.
        m_r <= op ? rt_val : rs_val;
        hi  <= '0;
        lo  <= op ? rs_val : rt_val;
      end
    end else if (state == RUN && step_adv) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 5'd1;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign alu_req = alu.req;
  assign alu_opA = alu.a;
  assign alu_opB = alu.b;
  assign alu_op  = alu.op;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded bench for muldiv_seq with a bench-side ALU and controllable grant.
module tb_muldiv_seq;
  import mips_pkg::*;

  logic        clk, rst_n, start, op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_by_zero, alu_req, alu_gnt;
  logic [31:0] hi, lo, alu_opA, alu_opB, alu_result;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_op(alu_op), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    if (alu_op == 4'b0010)      alu_result = alu_opA + alu_opB;
    else if (alu_op == 4'b0110) alu_result = alu_opA - alu_opB;
  end

  // Drives one operation, follows it to done, pops the scoreboard and compares.
  task automatic run_op(input logic opv, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit rnd, input int exp_lat, input int inject_at);
    exp_t e, got;
    logic [63:0] p;
    logic [31:0] sa, sbv;
    logic [3:0]  so;
    int k;
    bit seen, req_seen, hold_valid;
    if (opv && b == 32'h0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
    end else if (opv) begin
      e.hi = a % b; e.lo = a / b; e.dbz = 1'b0;
    end else begin
      p = {32'h0, a} * {32'h0, b};
      e.hi = p[63:32]; e.lo = p[31:0]; e.dbz = 1'b0;
    end
    e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = opv; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    k = 1; seen = 0; req_seen = 0; hold_valid = 0;
    sa = '0; sbv = '0; so = '0;
    while (k <= 400 && !seen) begin
      alu_gnt = rnd ? 1'($urandom_range(0, 1)) : (k > stall);
      if (k == inject_at) begin
        start = 1'b1; op = 1'b0; rs_val = 32'hDEAD_0001; rt_val = 32'hBEEF_0002;
      end else if (k == inject_at + 1) start = 1'b0;
      @(negedge clk);
      if (alu_req) req_seen = 1;
      if (hold_valid) begin
        checks++;
        if (alu_opA !== sa || alu_opB !== sbv || alu_op !== so) begin
          errors++;
          $display("FAIL stall_hold k=%0d got A=%h B=%h op=%h want A=%h B=%h op=%h",
                   k, alu_opA, alu_opB, alu_op, sa, sbv, so);
        end
      end
      hold_valid = alu_req && !alu_gnt;
      sa = alu_opA; sbv = alu_opB; so = alu_op;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_high k=%0d got %b want 1", k, busy);
      end
      if (done === 1'b1) begin
        seen = 1;
        got = sb.pop_front();
        checks++;
        if (hi !== got.hi || lo !== got.lo) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, got.hi, got.lo);
        end
        checks++;
        if (div_by_zero !== got.dbz) begin
          errors++;
          $display("FAIL div_by_zero got %b want %b", div_by_zero, got.dbz);
        end
        if (got.lat > 0) begin
          checks++;
          if (k != got.lat) begin
            errors++;
            $display("FAIL latency got E+%0d want E+%0d", k, got.lat);
          end
        end
        if (got.dbz) begin
          checks++;
          if (req_seen) begin
            errors++;
            $display("FAIL div0_no_req got alu_req=1 want 0");
          end
        end
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout got no done want done by E+%0d", exp_lat);
      void'(sb.pop_front());
    end else begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL hold_after_done got busy=%b done=%b hi=%h lo=%h dbz=%b want 0 0 %h %h %b",
                 busy, done, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; rs_val = '0; rt_val = '0; alu_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, alu_req, hi, lo, alu_opA, alu_opB, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b dbz=%b req=%b hi=%h lo=%h A=%h B=%h op=%h want all 0",
               busy, done, div_by_zero, alu_req, hi, lo, alu_opA, alu_opB, alu_op);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b req=%b want 0 0", busy, alu_req);
    end
  endtask

  task automatic test_multu();
    run_op(1'b0, 32'd3, 32'd5, 0, 0, 33, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33, 0);
    run_op(1'b0, 32'h8000_0000, 32'd2, 0, 0, 33, 0);
  endtask

  task automatic test_divu();
    run_op(1'b1, 32'd100, 32'd7, 0, 0, 33, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 33, 0);
    run_op(1'b1, 32'd5, 32'd9, 0, 0, 33, 0);
  endtask

  task automatic test_div_by_zero();
    run_op(1'b1, 32'h1234, 32'h0, 0, 0, 1, 0);
  endtask

  task automatic test_stall();
    run_op(1'b0, 32'd7, 32'd1, 10, 0, 43, 0);
  endtask

  task automatic test_start_ignored();
    run_op(1'b1, 32'd1000, 32'd33, 0, 0, 33, 5);
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 32'h0, 32'h0, 0, 0, 1, 0);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 33, 0);
  endtask

  task automatic test_random_grant();
    for (int i = 0; i < 6; i++)
      run_op(1'(i % 2), $urandom, (i == 3) ? 32'd3 : $urandom, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    bit done_seen;
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'h1234; rt_val = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0; alu_gnt = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, alu_req, hi, lo, alu_opA, alu_opB, alu_op} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b dbz=%b req=%b hi=%h lo=%h A=%h B=%h op=%h want all 0",
               busy, done, div_by_zero, alu_req, hi, lo, alu_opA, alu_opB, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL no_done_after_reset got done/busy activity want none");
    end
    run_op(1'b0, 32'd6, 32'd7, 0, 0, 33, 0);
  endtask

  initial begin
    test_reset_state();
    test_multu();
    test_divu();
    test_div_by_zero();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_random_grant();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for MULTU/DIVU that performs the iterative add/subtract steps on the shared 32-bit ALU, not on a private adder. It sits beside the EX stage. The pipeline raises `start` with two operands. The block requests the ALU step by step through a req/gnt port and returns the 64-bit result in HI/LO. The core stalls on `busy`.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse to begin an operation; sampled only in IDLE.
- `op` in 1: operation select; 0 = MULTU, 1 = DIVU.
- `rs_val` in 32: multiplicand for MULTU, dividend for DIVU.
- `rt_val` in 32: multiplier for MULTU, divisor for DIVU.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when `hi`/`lo` are final.
- `hi` out 32: high word of the product, or the remainder.
- `lo` out 32: low word of the product, or the quotient.
- `div_by_zero` out 1: set with `done` when DIVU has `rt_val == 0`; cleared on the next accepted `start`.
- `alu_req` out 1: this cycle's step needs the ALU.
- `alu_gnt` in 1: combinational grant from the EX arbiter, valid in the same cycle.
- `alu_opA`, `alu_opB` out 32 each: ALU operands; 0 when `alu_req` is low.
- `alu_op` out 4: ALU operation code; 0 when `alu_req` is low.
- `alu_result` in 32: combinational ALU output, sampled on the edge where `alu_req && alu_gnt`.

## Operation
- ALU codes used:
  - ADD = 4'b0010.
  - SUB = 4'b0110.
  - No other code is driven.
- States and transitions:
  - IDLE → RUN on `start`.
  - IDLE → DONE on `start` with DIVU and `rt_val == 0`.
  - RUN → DONE after step 31 completes.
  - DONE → IDLE unconditionally.
- Start acceptance:
  - Latch the operands and `op`.
  - Clear `div_by_zero` and the step counter `cnt` (5 bits).
  - `start` is ignored in RUN and DONE.
- MULTU step:
  - Initial values: `hi`=0, `lo`=multiplier, M=multiplicand.
  - If `lo[0]` is 1: request ADD with A=`hi`, B=M. Carry c = (`alu_result` < M), unsigned. Then {`hi`,`lo`} ← {c, `alu_result`, `lo`} >> 1.
  - If `lo[0]` is 0: no request; {`hi`,`lo`} ← {1'b0, `hi`, `lo`} >> 1.
- DIVU step:
  - Initial values: `hi`=0, `lo`=dividend, D=divisor.
  - Form the 33-bit r = {`hi`, `lo[31]`}.
  - Always request SUB with A=r[31:0], B=D.
  - ge = r[32] | (r[31:0] >= D), unsigned.
  - `hi` ← ge ? `alu_result` : r[31:0]; `lo` ← {`lo[30:0]`, ge}.
- Stalls: a step that needs the ALU advances only when `alu_gnt` is high. With `alu_req && !alu_gnt` the state, `cnt` and registers hold, and the ALU drive stays stable.
- Divide by zero takes a shortcut: `hi`=`rs_val`, `lo`=32'hFFFF_FFFF, `div_by_zero`=1.
- `hi`/`lo` hold their values after `done` until the next accepted `start`.

## Timing
- Reset values:
  - State = IDLE.
  - `hi`, `lo`, `cnt` = 0.
  - `busy`, `done`, `div_by_zero`, `alu_req` = 0.
  - ALU drive = 0.
- Reset mid-operation aborts immediately; the aborted operation produces no `done`.
- Latency with no stalls: `start` is accepted at edge E, RUN occupies the 32 cycles after E, and `done` is high in cycle E+33. Every denied grant cycle adds exactly one cycle.
- Divide-by-zero latency: `done` is high in cycle E+1.
- `busy` rises in cycle E+1 and falls with the IDLE return after `done`. A `start` in the cycle after `done` is accepted.
- `alu_req`, `alu_opA`, `alu_opB` and `alu_op` are combinational from the registered state. There is no combinational path from `start` to the outputs.

## Structure
- Shared package `mips_pkg` holds:
  - The ALU op constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100).
  - The `muldiv_op` encoding.
  - The state enum (IDLE, RUN, DONE).
- One natural sub-module, `muldiv_step`: purely combinational next-{`hi`,`lo`}, `alu_req` and operand generation for one step. `muldiv_seq` keeps the FSM, `cnt` and the registers.

## Test plan
- MULTU 3 × 5 with `alu_gnt` tied high → `done` at E+33, `hi`=0, `lo`=0x0000_000F, `busy` high for cycles E+1 through E+33.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001. This exercises the carry path.
- DIVU 100 / 7 → `lo`=14, `hi`=2.
- DIVU 0xFFFF_FFFF / 0x8000_0001 → `lo`=1, `hi`=0x7FFF_FFFE. This exercises r[32]=1.
- DIVU 0x1234 / 0 → `done` at E+1, `hi`=0x1234, `lo`=0xFFFF_FFFF, `div_by_zero`=1, `alu_req` never high.
- Stall case: MULTU 7 × 1 with `alu_gnt` low for the first 10 cycles of RUN. Only step 0 requests the ALU, so `done` lands at E+43 with `lo`=7. `alu_opA`/`alu_opB` are stable through the stall.
- Reset case: `rst_n` pulsed low mid-RUN → all outputs 0 asynchronously and no `done` follows. Separately, a `start` raised during RUN → ignored and the result unchanged.
